beam_mult_scheduler: RTL and testbench

- Time-multiplexes one external 2-stage complex multiplier (I+jQ)*(Cr+jCi) across NUM_CH antenna channels and NUM_BEAMS beams.
- Buffers one channel snapshot and holds a writable per-beam/per-channel weight bank.
- Issues one multiply per cycle, accumulates products per beam, and emits one complex beam sum per beam over a valid/ready port.
- Sits between the channelised ADC sample stream and the beam output formatter.

---
 rtl/beamformer_pkg.sv | 28 ++
 rtl/beam_coef_bank.sv | 32 +++
 rtl/beam_mult_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_beam_mult_scheduler.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/beamformer_pkg.sv
// Shared FSM states, multiplier tag layout and width helper for the beam multiplier scheduler.
package beamformer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_WAIT_OUT = 3'd4
    } state_t;

    localparam int TAG_VALID_W = 1;
    localparam int TAG_FIRST_W = 1;
    localparam int TAG_LAST_W  = 1;
    localparam int TAG_W       = TAG_VALID_W + TAG_FIRST_W + TAG_LAST_W;

    // Travels beside each operand set so the accumulator knows what the product belongs to.
    typedef struct packed {
        logic [TAG_VALID_W-1:0] valid;
        logic [TAG_FIRST_W-1:0] first;
        logic [TAG_LAST_W-1:0]  last;
    } tag_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/beam_coef_bank.sv
// Per-beam/per-channel complex weight register file: one synchronous write, one combinational read.
module beam_coef_bank #(
    parameter int COEFF_WIDTH = 16,
    parameter int DEPTH       = 8,
    parameter int ADDR_W      = 3
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic signed [COEFF_WIDTH-1:0] wr_real,
    input  logic signed [COEFF_WIDTH-1:0] wr_imag,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic signed [COEFF_WIDTH-1:0] rd_real,
    output logic signed [COEFF_WIDTH-1:0] rd_imag
);

    logic signed [COEFF_WIDTH-1:0] mem_real [DEPTH];
    logic signed [COEFF_WIDTH-1:0] mem_imag [DEPTH];

    // NOTE: storage arrays get no reset; software initialises them, and a reset would turn the array into flops with a reset tree.
    always_ff @(posedge clk) begin
        if (wr_en && (int'(wr_addr) < DEPTH)) begin
            mem_real[wr_addr] <= wr_real;
            mem_imag[wr_addr] <= wr_imag;
        end
    end

    // Combinational read returns the pre-write value when read and write collide.
    assign rd_real = mem_real[rd_addr];
    assign rd_imag = mem_imag[rd_addr];

endmodule

// File: rtl/beam_mult_scheduler.sv
// Time-multiplexes one external complex multiplier over NUM_CH channels x NUM_BEAMS beams.
// Optional: define BEAM_MULT_SCHED_CONJ_EN to feed -weight_imag (x*conj(w)) to the multiplier.
module beam_mult_scheduler
    import beamformer_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int COEFF_WIDTH  = 16,
    parameter int OUT_WIDTH    = 32,
    parameter int NUM_CH       = 4,
    parameter int NUM_BEAMS    = 2,
    parameter int MULT_LATENCY = 2,
    parameter int ACC_WIDTH    = OUT_WIDTH + $clog2(NUM_CH)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic signed [DATA_WIDTH-1:0]           in_i,
    input  logic signed [DATA_WIDTH-1:0]           in_q,
    input  logic                                   coef_wr_en,
    input  logic [clog2_min1(NUM_BEAMS*NUM_CH)-1:0] coef_wr_addr,
    input  logic signed [COEFF_WIDTH-1:0]          coef_wr_real,
    input  logic signed [COEFF_WIDTH-1:0]          coef_wr_imag,
    output logic signed [DATA_WIDTH-1:0]           mul_i,
    output logic signed [DATA_WIDTH-1:0]           mul_q,
    output logic signed [COEFF_WIDTH-1:0]          mul_cr,
    output logic signed [COEFF_WIDTH-1:0]          mul_ci,
    input  logic signed [OUT_WIDTH-1:0]            mul_real,
    input  logic signed [OUT_WIDTH-1:0]            mul_imag,
    output logic                                   beam_valid,
    input  logic                                   beam_ready,
    output logic signed [ACC_WIDTH-1:0]            beam_real,
    output logic signed [ACC_WIDTH-1:0]            beam_imag,
    output logic [clog2_min1(NUM_BEAMS)-1:0]       beam_idx,
    output logic                                   busy
);

    localparam int DEPTH  = NUM_BEAMS * NUM_CH;
    localparam int ADDR_W = clog2_min1(DEPTH);
    localparam int CH_W   = clog2_min1(NUM_CH);
    localparam int BEAM_W = clog2_min1(NUM_BEAMS);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);
    localparam logic [BEAM_W-1:0] BEAM_LAST = BEAM_W'(NUM_BEAMS - 1);

    state_t              state_q, state_d;
    logic [CH_W-1:0]     ch_cnt_q, ch_cnt_d;
    logic [BEAM_W-1:0]   beam_cnt_q, beam_cnt_d;
    logic                accept, issue;

    logic signed [DATA_WIDTH-1:0]  samp_i [NUM_CH];
    logic signed [DATA_WIDTH-1:0]  samp_q [NUM_CH];
    logic [ADDR_W-1:0]             coef_rd_addr;
    logic signed [COEFF_WIDTH-1:0] coef_rd_real, coef_rd_imag, coef_ci_eff;

    tag_t                          tag_pipe [MULT_LATENCY+1];
    tag_t                          tag_out;
    logic                          beam_done;
    logic signed [ACC_WIDTH-1:0]   acc_re_q, acc_im_q, sum_re, sum_im;

    beam_coef_bank #(
        .COEFF_WIDTH (COEFF_WIDTH),
        .DEPTH       (DEPTH),
        .ADDR_W      (ADDR_W)
    ) u_coef_bank (
        .clk     (clk),
        .wr_en   (coef_wr_en),
        .wr_addr (coef_wr_addr),
        .wr_real (coef_wr_real),
        .wr_imag (coef_wr_imag),
        .rd_addr (coef_rd_addr),
        .rd_real (coef_rd_real),
        .rd_imag (coef_rd_imag)
    );

    assign coef_rd_addr = ADDR_W'(int'(beam_cnt_q) * NUM_CH + int'(ch_cnt_q));

`ifdef BEAM_MULT_SCHED_CONJ_EN
    localparam logic signed [COEFF_WIDTH-1:0] COEF_MIN = {1'b1, {(COEFF_WIDTH-1){1'b0}}};
    localparam logic signed [COEFF_WIDTH-1:0] COEF_MAX = {1'b0, {(COEFF_WIDTH-1){1'b1}}};
    // Negating the most-negative weight would wrap onto itself, so clamp it to the most positive.
    assign coef_ci_eff = (coef_rd_imag == COEF_MIN) ? COEF_MAX : -coef_rd_imag;
`else
    assign coef_ci_eff = coef_rd_imag;
`endif

    assign tag_out   = tag_pipe[MULT_LATENCY];
    assign beam_done = (state_q == ST_DRAIN) && tag_out.valid[0] && tag_out.last[0];
    assign sum_re    = (tag_out.first[0] ? '0 : acc_re_q) + ACC_WIDTH'(mul_real);
    assign sum_im    = (tag_out.first[0] ? '0 : acc_im_q) + ACC_WIDTH'(mul_imag);

    assign in_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign busy     = (state_q != ST_IDLE);

    // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        ch_cnt_d   = ch_cnt_q;
        beam_cnt_d = beam_cnt_q;
        accept     = 1'b0;
        issue      = 1'b0;
        case (state_q)
            ST_IDLE, ST_LOAD: begin
                accept = in_valid;
                if (in_valid) begin
                    if (ch_cnt_q == CH_LAST) begin
                        state_d    = ST_ISSUE;
                        ch_cnt_d   = '0;
                        beam_cnt_d = '0;
                    end else begin
                        state_d  = ST_LOAD;
                        ch_cnt_d = ch_cnt_q + CH_W'(1);
                    end
                end
            end
            ST_ISSUE: begin
                issue = 1'b1;
                if (ch_cnt_q == CH_LAST) begin
                    state_d  = ST_DRAIN;
                    ch_cnt_d = '0;
                end else begin
                    ch_cnt_d = ch_cnt_q + CH_W'(1);
                end
            end
            ST_DRAIN: begin
                if (beam_done) state_d = ST_WAIT_OUT;
            end
            ST_WAIT_OUT: begin
                if (beam_ready) begin
                    if (beam_cnt_q == BEAM_LAST) begin
                        state_d    = ST_IDLE;
                        beam_cnt_d = '0;
                    end else begin
                        state_d    = ST_ISSUE;
                        beam_cnt_d = beam_cnt_q + BEAM_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: clocked blocks use non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ch_cnt_q   <= '0;
            beam_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ch_cnt_q   <= ch_cnt_d;
            beam_cnt_q <= beam_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            samp_i[ch_cnt_q] <= in_i;
            samp_q[ch_cnt_q] <= in_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_i      <= '0;
            mul_q      <= '0;
            mul_cr     <= '0;
            mul_ci     <= '0;
            for (int i = 0; i <= MULT_LATENCY; i++) tag_pipe[i] <= '0;
            acc_re_q   <= '0;
            acc_im_q   <= '0;
            beam_valid <= 1'b0;
            beam_real  <= '0;
            beam_imag  <= '0;
            beam_idx   <= '0;
        end else begin
            if (issue) begin
                mul_i  <= samp_i[ch_cnt_q];
                mul_q  <= samp_q[ch_cnt_q];
                mul_cr <= coef_rd_real;
                mul_ci <= coef_ci_eff;
            end
            tag_pipe[0].valid <= issue;
            tag_pipe[0].first <= (ch_cnt_q == '0);
            tag_pipe[0].last  <= (ch_cnt_q == CH_LAST);
            for (int i = 1; i <= MULT_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];

            if (tag_out.valid[0]) begin
                acc_re_q <= sum_re;
                acc_im_q <= sum_im;
            end

            if (beam_done) begin
                beam_real  <= sum_re;
                beam_imag  <= sum_im;
                beam_idx   <= beam_cnt_q;
                beam_valid <= 1'b1;
            end else if ((state_q == ST_WAIT_OUT) && beam_ready) begin
                beam_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_beam_mult_scheduler.sv
// Randomised self-checking bench for beam_mult_scheduler with a two-stage complex multiplier stand-in.
module tb_beam_mult_scheduler;

    localparam int DW    = 16;
    localparam int CW    = 16;
    localparam int OW    = 32;
    localparam int NCH   = 4;
    localparam int NB    = 2;
    localparam int ML    = 2;
    localparam int ACC_W = OW + $clog2(NCH);
    localparam int DEPTH = NB * NCH;
    localparam int AW    = $clog2(DEPTH);
    localparam int BW    = (NB > 2) ? $clog2(NB) : 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] in_i = '0, in_q = '0;
    logic                 coef_wr_en = 1'b0;
    logic [AW-1:0]        coef_wr_addr = '0;
    logic signed [CW-1:0] coef_wr_real = '0, coef_wr_imag = '0;
    logic signed [DW-1:0] mul_i, mul_q;
    logic signed [CW-1:0] mul_cr, mul_ci;
    logic signed [OW-1:0] mul_real = '0, mul_imag = '0;
    logic                 beam_valid;
    logic                 beam_ready = 1'b0;
    logic signed [ACC_W-1:0] beam_real, beam_imag;
    logic [BW-1:0]        beam_idx;
    logic                 busy;

    beam_mult_scheduler #(
        .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .OUT_WIDTH(OW),
        .NUM_CH(NCH), .NUM_BEAMS(NB), .MULT_LATENCY(ML)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_i(in_i), .in_q(in_q),
        .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr),
        .coef_wr_real(coef_wr_real), .coef_wr_imag(coef_wr_imag),
        .mul_i(mul_i), .mul_q(mul_q), .mul_cr(mul_cr), .mul_ci(mul_ci),
        .mul_real(mul_real), .mul_imag(mul_imag),
        .beam_valid(beam_valid), .beam_ready(beam_ready),
        .beam_real(beam_real), .beam_imag(beam_imag), .beam_idx(beam_idx),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the external complex multiplier: two register stages.
    logic signed [OW-1:0] p_re = '0, p_im = '0;
    always @(posedge clk) begin
        p_re     <= OW'(longint'(mul_i) * longint'(mul_cr) - longint'(mul_q) * longint'(mul_ci));
        p_im     <= OW'(longint'(mul_i) * longint'(mul_ci) + longint'(mul_q) * longint'(mul_cr));
        mul_real <= p_re;
        mul_imag <= p_im;
    end

    // Reference model state: the snapshot and weight bank as software sees them.
    logic signed [DW-1:0] s_i [NCH];
    logic signed [DW-1:0] s_q [NCH];
    logic signed [CW-1:0] w_re [DEPTH];
    logic signed [CW-1:0] w_im [DEPTH];
    longint               got_re [NB];
    longint               got_im [NB];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic longint eff_ci(input int a);
        longint v;
        v = longint'(w_im[a]);
`ifdef BEAM_MULT_SCHED_CONJ_EN
        v = (v == -32768) ? 32767 : -v;
`endif
        return v;
    endfunction

    function automatic longint wrap_acc(input longint v);
        logic signed [ACC_W-1:0] t;
        t = v[ACC_W-1:0];
        return longint'(t);
    endfunction

    // Beam b = sum over channels of x[c] * w[b][c], complex, wrapped to the accumulator width.
    task automatic expect_beam(input int b, output longint re, output longint im);
        longint xi, xq, cr, ci;
        re = 0;
        im = 0;
        for (int c = 0; c < NCH; c++) begin
            xi = longint'(s_i[c]);
            xq = longint'(s_q[c]);
            cr = longint'(w_re[b*NCH + c]);
            ci = eff_ci(b*NCH + c);
            re += xi * cr - xq * ci;
            im += xi * ci + xq * cr;
        end
        re = wrap_acc(re);
        im = wrap_acc(im);
    endtask

    task automatic load_weights();
        for (int a = 0; a < DEPTH; a++) begin
            @(negedge clk);
            coef_wr_en   = 1'b1;
            coef_wr_addr = AW'(a);
            coef_wr_real = w_re[a];
            coef_wr_imag = w_im[a];
        end
        @(negedge clk);
        coef_wr_en = 1'b0;
    endtask

    task automatic rand_weights();
        for (int a = 0; a < DEPTH; a++) begin
            w_re[a] = CW'($urandom);
            w_im[a] = CW'($urandom);
        end
    endtask

    task automatic rand_samples();
        for (int c = 0; c < NCH; c++) begin
            s_i[c] = DW'($urandom);
            s_q[c] = DW'($urandom);
        end
    endtask

    // Returns the cycle count seen just after the final sample was accepted.
    task automatic send_samples(input bit gaps, output int ref_cyc);
        for (int c = 0; c < NCH; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            check("in_ready_load", in_ready, 1);
            in_valid = 1'b1;
            in_i     = s_i[c];
            in_q     = s_q[c];
        end
        @(negedge clk);
        in_valid = 1'b0;
        ref_cyc  = cyc;
    endtask

    task automatic receive_beams(input int ref_cyc, input int hold0, input bit rnd, input bit rewrite_b1);
        int     rc;
        int     hold;
        bit     got;
        longint er, ei;
        rc = ref_cyc;
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < NCH; c++) begin
                @(negedge clk);
                beam_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                check("mul_i", mul_i, s_i[c]);
                check("mul_q", mul_q, s_q[c]);
                check("mul_cr", mul_cr, w_re[b*NCH + c]);
                check("mul_ci", mul_ci, eff_ci(b*NCH + c));
                check("in_ready_issue", in_ready, 0);
            end
            beam_ready = 1'b0;
            got = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (beam_valid) begin
                    got = 1'b1;
                    break;
                end
            end
            check("beam_valid_seen", got, 1);
            check("latency", cyc - rc, NCH + ML + 1);
            expect_beam(b, er, ei);
            check("beam_real", beam_real, er);
            check("beam_imag", beam_imag, ei);
            check("beam_idx", beam_idx, b);
            got_re[b] = beam_real;
            got_im[b] = beam_imag;
            hold = rnd ? int'($urandom_range(0, 3)) : hold0;
            for (int h = 0; h < hold; h++) begin
                if (rewrite_b1 && b == 0 && h < NCH) begin
                    w_re[NCH + h] = CW'($urandom);
                    w_im[NCH + h] = CW'($urandom);
                    coef_wr_en    = 1'b1;
                    coef_wr_addr  = AW'(NCH + h);
                    coef_wr_real  = w_re[NCH + h];
                    coef_wr_imag  = w_im[NCH + h];
                end else begin
                    coef_wr_en = 1'b0;
                end
                @(negedge clk);
                check("hold_valid", beam_valid, 1);
                check("hold_real", beam_real, er);
                check("hold_imag", beam_imag, ei);
                check("hold_in_ready", in_ready, 0);
            end
            coef_wr_en = 1'b0;
            beam_ready = 1'b1;
            @(negedge clk);
            beam_ready = 1'b0;
            rc = cyc;
            check("valid_after_hs", beam_valid, 0);
        end
        check("busy_done", busy, 0);
        check("in_ready_done", in_ready, 1);
    endtask

    task automatic run_snapshot(input bit rnd, input int hold0, input bit rewrite_b1);
        int rc;
        send_samples(rnd, rc);
        receive_beams(rc, hold0, rnd, rewrite_b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rc;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_beam_valid", beam_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_mul_i", mul_i, 0);
        check("rst_mul_ci", mul_ci, 0);
        check("rst_beam_real", beam_real, 0);
        check("rst_beam_idx", beam_idx, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);

        // Unit response
        for (int a = 0; a < DEPTH; a++) begin
            w_re[a] = (a < NCH) ? CW'(1) : CW'(0);
            w_im[a] = (a < NCH) ? CW'(0) : CW'(1);
        end
        for (int c = 0; c < NCH; c++) begin
            s_i[c] = DW'(2*c + 1);
            s_q[c] = DW'(2*c + 2);
        end
        load_weights();
        run_snapshot(1'b0, 0, 1'b0);
`ifdef BEAM_MULT_SCHED_CONJ_EN
        check("unit_b0_re", got_re[0], 16);
        check("unit_b0_im", got_im[0], 20);
        check("unit_b1_re", got_re[1], 20);
        check("unit_b1_im", got_im[1], -16);
`else
        check("unit_b0_re", got_re[0], 16);
        check("unit_b0_im", got_im[0], 20);
        check("unit_b1_re", got_re[1], -20);
        check("unit_b1_im", got_im[1], 16);
`endif

        // Conjugate-sensitive response: weight (0,1), sample (1,2) on every channel
        for (int a = 0; a < DEPTH; a++) begin
            w_re[a] = CW'(0);
            w_im[a] = CW'(1);
        end
        for (int c = 0; c < NCH; c++) begin
            s_i[c] = DW'(1);
            s_q[c] = DW'(2);
        end
        load_weights();
        run_snapshot(1'b0, 0, 1'b0);
`ifdef BEAM_MULT_SCHED_CONJ_EN
        check("conj_re", got_re[0], 8);
        check("conj_im", got_im[0], -4);
`else
        check("conj_re", got_re[0], -8);
        check("conj_im", got_im[0], 4);
`endif

        // Backpressure on beam 0, with beam 1 weights rewritten while waiting
        rand_weights();
        rand_samples();
        load_weights();
        run_snapshot(1'b0, 10, 1'b1);

        // Full-scale accumulation
        for (int a = 0; a < DEPTH; a++) begin
            w_re[a] = CW'(32767);
            w_im[a] = CW'(0);
        end
        for (int c = 0; c < NCH; c++) begin
            s_i[c] = DW'(32767);
            s_q[c] = DW'(0);
        end
        load_weights();
        run_snapshot(1'b0, 0, 1'b0);
        check("wrap_re", got_re[0], 64'sd4294705156);
        check("wrap_im", got_im[0], 0);

        // Reset while issuing channel 2
        rand_weights();
        load_weights();
        rand_samples();
        send_samples(1'b0, rc);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", beam_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("postrst_valid", beam_valid, 0);
            check("postrst_in_ready", in_ready, 1);
            check("postrst_busy", busy, 0);
        end
        rand_samples();
        run_snapshot(1'b0, 0, 1'b0);

        // Randomised traffic with random gaps and backpressure
        for (int t = 0; t < 20; t++) begin
            if (t % 4 == 0) begin
                rand_weights();
                load_weights();
            end
            rand_samples();
            run_snapshot(1'b1, 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
